// File: rtl/ysyx_220066_exec_alu_nxtpc.sv
// ---------------------------------------------------------------------------
// ysyx_220066_exec_alu_nxtpc
//
// Execute-stage compute core: one input register bank captured from decode,
// feeding a 64-bit integer ALU and a next-PC / branch resolver. Everything
// downstream of the register bank is combinational, so the outputs describe
// the instruction that was captured on the last unstalled clock edge.
//
// Ports
//   clk, rst        single rising-edge clock, asynchronous active-high reset
//   block           stall: 1 = every input register holds (including valid)
//   valid_in        incoming instruction valid
//   src1_in/src2_in rs1 / rs2 values
//   imm_in          32-bit immediate, sign-extended to 64 internally
//   csr_data_in     CSR read value (B operand source 11)
//   pc_in           instruction PC
//   ALUAsrc_in      A operand: 0 = src1, 1 = pc
//   ALUBsrc_in      B operand: 00 src2, 01 const 4, 10 imm, 11 csr_data
//   ALUctr_in       [4] = 32-bit word op, [3:0] = operation
//   Branch_in       branch / jump type
//   valid           registered valid
//   result, zero    ALU result and (result == 0)
//   nxtpc, is_jmp   next PC (ungated) and taken flag (gated by valid)
// ---------------------------------------------------------------------------
module ysyx_220066_exec_alu_nxtpc (
    input  logic        clk,
    input  logic        rst,
    input  logic        block,
    input  logic        valid_in,
    input  logic [63:0] src1_in,
    input  logic [63:0] src2_in,
    input  logic [31:0] imm_in,
    input  logic [63:0] csr_data_in,
    input  logic [63:0] pc_in,
    input  logic        ALUAsrc_in,
    input  logic [1:0]  ALUBsrc_in,
    input  logic [4:0]  ALUctr_in,
    input  logic [2:0]  Branch_in,
    output logic        valid,
    output logic [63:0] result,
    output logic        zero,
    output logic [63:0] nxtpc,
    output logic        is_jmp
);

    // ALU operation codes (ALUctr[3:0])
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b1000;
    localparam logic [3:0] OP_SLL   = 4'b0001;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SRA   = 4'b1101;
    localparam logic [3:0] OP_SLT   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b0111;
    localparam logic [3:0] OP_COPYB = 4'b1110;

    // Branch codes
    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam logic [2:0] BR_BEQ  = 3'b100;
    localparam logic [2:0] BR_BNE  = 3'b101;
    localparam logic [2:0] BR_BLT  = 3'b110;
    localparam logic [2:0] BR_BGE  = 3'b111;

    // B operand select
    localparam logic [1:0] BSEL_SRC2 = 2'b00;
    localparam logic [1:0] BSEL_FOUR = 2'b01;
    localparam logic [1:0] BSEL_IMM  = 2'b10;
    localparam logic [1:0] BSEL_CSR  = 2'b11;

    typedef struct packed {
        logic        valid;
        logic [63:0] src1;
        logic [63:0] src2;
        logic [31:0] imm;
        logic [63:0] csr_data;
        logic [63:0] pc;
        logic        asrc;
        logic [1:0]  bsrc;
        logic [4:0]  ctr;
        logic [2:0]  branch;
    } ex_reg_t;

    ex_reg_t r;
    ex_reg_t r_in;

    // ------------------------------------------------------------------
    // Input register bank
    // ------------------------------------------------------------------
    always_comb begin
        r_in          = '0;
        r_in.valid    = valid_in;
        r_in.src1     = src1_in;
        r_in.src2     = src2_in;
        r_in.imm      = imm_in;
        r_in.csr_data = csr_data_in;
        r_in.pc       = pc_in;
        r_in.asrc     = ALUAsrc_in;
        r_in.bsrc     = ALUBsrc_in;
        r_in.ctr      = ALUctr_in;
        r_in.branch   = Branch_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
        end else if (!block) begin
            r <= r_in;
        end
    end

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    logic [63:0] imm64;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        word_op;
    logic [3:0]  op;

    assign imm64   = {{32{r.imm[31]}}, r.imm};
    assign op_a    = r.asrc ? r.pc : r.src1;
    assign word_op = r.ctr[4];
    assign op      = r.ctr[3:0];

    always_comb begin
        op_b = r.src2;
        case (r.bsrc)
            BSEL_SRC2: op_b = r.src2;
            BSEL_FOUR: op_b = 64'd4;
            BSEL_IMM:  op_b = imm64;
            BSEL_CSR:  op_b = r.csr_data;
            default:   op_b = r.src2;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared add/subtract: SUB is A + ~B + 1.
    // ------------------------------------------------------------------
    logic        is_sub;
    logic [63:0] b_eff;
    logic [63:0] sum;

    assign is_sub = (op == OP_SUB);
    assign b_eff  = is_sub ? ~op_b : op_b;
    assign sum    = op_a + b_eff + {63'd0, is_sub};

    // ------------------------------------------------------------------
    // Shifter. Word right shifts pre-extend A[31:0] (zero for SRLW,
    // sign for SRAW) so a single 64-bit shifter serves both widths; the
    // final W sign-extension then only has to look at bits [31:0].
    // ------------------------------------------------------------------
    logic [5:0]  shamt;
    logic [63:0] shr_src;
    logic [63:0] sll_res;
    logic [63:0] srl_res;
    logic [63:0] sra_res;

    assign shamt = word_op ? {1'b0, op_b[4:0]} : op_b[5:0];

    always_comb begin
        shr_src = op_a;
        if (word_op) begin
            if (op == OP_SRA) shr_src = {{32{op_a[31]}}, op_a[31:0]};
            else              shr_src = {32'd0, op_a[31:0]};
        end
    end

    assign sll_res = op_a << shamt;
    assign srl_res = shr_src >> shamt;
    assign sra_res = $unsigned($signed(shr_src) >>> shamt);

    // ------------------------------------------------------------------
    // Comparators
    // ------------------------------------------------------------------
    logic lt_s;
    logic lt_u;

    assign lt_s = ($signed(op_a) < $signed(op_b));
    assign lt_u = (op_a < op_b);

    // ------------------------------------------------------------------
    // Result mux and word sign-extension
    // ------------------------------------------------------------------
    logic [63:0] raw;

    always_comb begin
        raw = 64'd0;
        case (op)
            OP_ADD,
            OP_SUB:   raw = sum;
            OP_SLL:   raw = sll_res;
            OP_SRL:   raw = srl_res;
            OP_SRA:   raw = sra_res;
            OP_SLT:   raw = {63'd0, lt_s};
            OP_SLTU:  raw = {63'd0, lt_u};
            OP_XOR:   raw = op_a ^ op_b;
            OP_OR:    raw = op_a | op_b;
            OP_AND:   raw = op_a & op_b;
            OP_COPYB: raw = op_b;
            default:  raw = 64'd0;
        endcase
    end

    assign result = word_op ? {{32{raw[31]}}, raw[31:0]} : raw;
    assign zero   = (result == 64'd0);
    assign valid  = r.valid;

    // ------------------------------------------------------------------
    // Next-PC resolution. JALR adds to the register src1, not the A
    // operand, because the ALU is busy forming the link value pc+4.
    // ------------------------------------------------------------------
    logic [63:0] pc_seq;
    logic [63:0] pc_rel;
    logic [63:0] pc_reg;
    logic        taken;

    assign pc_seq = r.pc + 64'd4;
    assign pc_rel = r.pc + imm64;
    assign pc_reg = (r.src1 + imm64) & ~64'h1;

    always_comb begin
        taken = 1'b0;
        nxtpc = pc_seq;
        case (r.branch)
            BR_NONE: begin
                taken = 1'b0;
                nxtpc = pc_seq;
            end
            BR_JAL: begin
                taken = 1'b1;
                nxtpc = pc_rel;
            end
            BR_JALR: begin
                taken = 1'b1;
                nxtpc = pc_reg;
            end
            BR_BEQ: begin
                taken = zero;
                nxtpc = zero ? pc_rel : pc_seq;
            end
            BR_BNE: begin
                taken = !zero;
                nxtpc = !zero ? pc_rel : pc_seq;
            end
            BR_BLT: begin
                taken = result[0];
                nxtpc = result[0] ? pc_rel : pc_seq;
            end
            BR_BGE: begin
                taken = !result[0];
                nxtpc = !result[0] ? pc_rel : pc_seq;
            end
            default: begin
                // reserved code behaves like no branch
                taken = 1'b0;
                nxtpc = pc_seq;
            end
        endcase
    end

    assign is_jmp = taken && r.valid;

endmodule

// File: tb/tb_ysyx_220066_exec_alu_nxtpc.sv
module tb_ysyx_220066_exec_alu_nxtpc;

    typedef struct packed {
        logic        valid;
        logic [63:0] src1;
        logic [63:0] src2;
        logic [31:0] imm;
        logic [63:0] csr;
        logic [63:0] pc;
        logic        asrc;
        logic [1:0]  bsrc;
        logic [4:0]  ctr;
        logic [2:0]  br;
    } ins_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        blk = 1'b0;
    ins_t        cur = '0;

    logic        valid;
    logic [63:0] result;
    logic        zero;
    logic [63:0] nxtpc;
    logic        is_jmp;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ysyx_220066_exec_alu_nxtpc dut (
        .clk         (clk),
        .rst         (rst),
        .block       (blk),
        .valid_in    (cur.valid),
        .src1_in     (cur.src1),
        .src2_in     (cur.src2),
        .imm_in      (cur.imm),
        .csr_data_in (cur.csr),
        .pc_in       (cur.pc),
        .ALUAsrc_in  (cur.asrc),
        .ALUBsrc_in  (cur.bsrc),
        .ALUctr_in   (cur.ctr),
        .Branch_in   (cur.br),
        .valid       (valid),
        .result      (result),
        .zero        (zero),
        .nxtpc       (nxtpc),
        .is_jmp      (is_jmp)
    );

    // Behavioural model: what an instruction must produce, from the ISA rules.
    function automatic void model(input ins_t s, output logic [63:0] res,
                                  output logic [63:0] np, output logic jmp);
        logic [63:0] imm64, a, b;
        logic [31:0] a32, b32, r32;
        logic        tk;
        imm64 = {{32{s.imm[31]}}, s.imm};
        a = s.asrc ? s.pc : s.src1;
        case (s.bsrc)
            2'd0: b = s.src2;
            2'd1: b = 64'd4;
            2'd2: b = imm64;
            default: b = s.csr;
        endcase
        a32 = a[31:0];
        b32 = b[31:0];
        if (!s.ctr[4]) begin
            case (s.ctr[3:0])
                4'd0:  res = a + b;
                4'd8:  res = a - b;
                4'd1:  res = a << b[5:0];
                4'd5:  res = a >> b[5:0];
                4'd13: res = $signed(a) >>> b[5:0];
                4'd2:  res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                4'd3:  res = (a < b) ? 64'd1 : 64'd0;
                4'd4:  res = a ^ b;
                4'd6:  res = a | b;
                4'd7:  res = a & b;
                4'd14: res = b;
                default: res = 64'd0;
            endcase
        end else begin
            case (s.ctr[3:0])
                4'd0:  r32 = a32 + b32;
                4'd8:  r32 = a32 - b32;
                4'd1:  r32 = a32 << b[4:0];
                4'd5:  r32 = a32 >> b[4:0];
                4'd13: r32 = $signed(a32) >>> b[4:0];
                4'd2:  r32 = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                4'd3:  r32 = (a < b) ? 32'd1 : 32'd0;
                4'd4:  r32 = a32 ^ b32;
                4'd6:  r32 = a32 | b32;
                4'd7:  r32 = a32 & b32;
                4'd14: r32 = b32;
                default: r32 = 32'd0;
            endcase
            res = {{32{r32[31]}}, r32};
        end
        case (s.br)
            3'd1, 3'd2: tk = 1'b1;
            3'd4: tk = (res == 64'd0);
            3'd5: tk = (res != 64'd0);
            3'd6: tk = res[0];
            3'd7: tk = !res[0];
            default: tk = 1'b0;
        endcase
        if (s.br == 3'd1)      np = s.pc + imm64;
        else if (s.br == 3'd2) np = (s.src1 + imm64) & ~64'h1;
        else if (tk)           np = s.pc + imm64;
        else                   np = s.pc + 64'd4;
        jmp = tk && s.valid;
    endfunction

    task automatic chk(input string nm, input logic ev, input logic [63:0] er,
                       input logic ez, input logic [63:0] enp, input logic ej);
        nvec++;
        if (valid !== ev || result !== er || zero !== ez || nxtpc !== enp || is_jmp !== ej) begin
            nerr++;
            $display("FAIL %s: got v=%0b r=%h z=%0b np=%h j=%0b, want v=%0b r=%h z=%0b np=%h j=%0b",
                     nm, valid, result, zero, nxtpc, is_jmp, ev, er, ez, enp, ej);
        end
    endtask

    // Compare process: tracks the held instruction and checks every cycle.
    ins_t held = '0;
    initial begin
        logic [63:0] er, enp;
        logic        ej;
        forever begin
            @(posedge clk);
            if (rst)       held = '0;
            else if (!blk) held = cur;
            #2;
            model(held, er, enp, ej);
            chk("model", held.valid, er, (er == 64'd0), enp, ej);
        end
    end

    task automatic apply(input ins_t s);
        @(negedge clk);
        cur = s;
        @(posedge clk);
        #3;
    endtask

    function automatic ins_t mk(input logic v, input logic [63:0] s1, input logic [63:0] s2,
                                input logic [31:0] im, input logic [63:0] pc,
                                input logic as, input logic [1:0] bs,
                                input logic [4:0] ct, input logic [2:0] br);
        ins_t s;
        s = '0;
        s.valid = v; s.src1 = s1; s.src2 = s2; s.imm = im; s.pc = pc;
        s.asrc = as; s.bsrc = bs; s.ctr = ct; s.br = br;
        s.csr = 64'hDEAD_BEEF_0000_1234;
        return s;
    endfunction

    initial begin
        ins_t s;
        repeat (2) @(posedge clk);
        #3;
        chk("reset", 1'b0, 64'd0, 1'b1, 64'h4, 1'b0);

        // reset held while stalled, with live inputs
        @(negedge clk);
        blk = 1'b1;
        cur = mk(1, 64'h10, 64'h20, 32'h40, 64'h100, 1, 2'b01, 5'b00000, 3'b001);
        @(posedge clk);
        #3;
        chk("reset_block", 1'b0, 64'd0, 1'b1, 64'h4, 1'b0);

        // release reset mid-cycle: nothing loads until the next edge
        @(negedge clk);
        blk = 1'b0;
        #1 rst = 1'b0;
        #1 chk("rst_release", 1'b0, 64'd0, 1'b1, 64'h4, 1'b0);
        @(posedge clk);
        #3;
        chk("first_load_jal", 1'b1, 64'h104, 1'b0, 64'h140, 1'b1);

        apply(mk(1, 64'h7FFF_FFFF, 0, 32'h1, 0, 0, 2'b10, 5'b00000, 3'b000));
        chk("add", 1'b1, 64'h0000_0000_8000_0000, 1'b0, 64'h4, 1'b0);
        apply(mk(1, 64'h7FFF_FFFF, 0, 32'h1, 0, 0, 2'b10, 5'b10000, 3'b000));
        chk("addw", 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0, 64'h4, 1'b0);
        apply(mk(1, 64'h8000_0000_0000_0000, 0, 32'd63, 0, 0, 2'b10, 5'b01101, 3'b000));
        chk("sra63", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h4, 1'b0);
        apply(mk(1, 64'h8000_0000, 0, 32'd4, 0, 0, 2'b10, 5'b11101, 3'b000));
        chk("sraw", 1'b1, 64'hFFFF_FFFF_F800_0000, 1'b0, 64'h4, 1'b0);
        apply(mk(1, 64'h8000_0000, 0, 32'd4, 0, 0, 2'b10, 5'b10101, 3'b000));
        chk("srlw", 1'b1, 64'h0000_0000_0800_0000, 1'b0, 64'h4, 1'b0);
        apply(mk(1, 64'd5, 64'd5, 32'h20, 64'h1000, 0, 2'b00, 5'b01000, 3'b100));
        chk("beq_taken", 1'b1, 64'd0, 1'b1, 64'h1020, 1'b1);
        apply(mk(1, 64'd5, 64'd6, 32'h20, 64'h1000, 0, 2'b00, 5'b01000, 3'b100));
        chk("beq_not", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h1004, 1'b0);
        apply(mk(1, 64'h2001, 0, 32'h2, 64'h3000, 1, 2'b01, 5'b00000, 3'b010));
        chk("jalr", 1'b1, 64'h3004, 1'b0, 64'h2002, 1'b1);
        apply(mk(0, 64'h2001, 0, 32'h2, 64'h3000, 1, 2'b01, 5'b00000, 3'b010));
        chk("jalr_invalid", 1'b0, 64'h3004, 1'b0, 64'h2002, 1'b0);
        apply(mk(1, 64'd3, 64'd9, 32'hFFFF_FFF0, 64'h500, 0, 2'b00, 5'b00010, 3'b110));
        chk("blt_neg_imm", 1'b1, 64'd1, 1'b0, 64'h4F0, 1'b1);
        apply(mk(1, 64'd3, 64'd9, 32'h8, 64'h500, 0, 2'b11, 5'b01110, 3'b011));
        chk("copyb_csr_rsvd", 1'b1, 64'hDEAD_BEEF_0000_1234, 1'b0, 64'h504, 1'b0);

        // stall: load BNE, then hold for 3 cycles while inputs churn
        apply(mk(1, 64'd1, 64'd2, 32'h10, 64'h800, 0, 2'b00, 5'b00100, 3'b101));
        chk("bne_load", 1'b1, 64'd3, 1'b0, 64'h810, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            blk = 1'b1;
            cur = mk(0, {$urandom, $urandom}, {$urandom, $urandom}, $urandom,
                     {$urandom, $urandom}, 1, 2'b10, 5'b01000, 3'b111);
            @(posedge clk);
            #3;
            chk("block_hold", 1'b1, 64'd3, 1'b0, 64'h810, 1'b1);
        end
        @(negedge clk);
        blk = 1'b0;

        // sweep every ALUctr code with mixed operands and branch types
        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            s = mk($urandom_range(0, 1), {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom, {$urandom, $urandom}, $urandom_range(0, 1),
                   2'($urandom_range(0, 3)), 5'(i), 3'($urandom_range(0, 7)));
            if (i % 5 == 0) s.src2 = s.src1;
            if (i % 7 == 0) s.src2 = {$urandom_range(0, 63), 26'd0, $urandom_range(0, 63)};
            cur = s;
            blk = ($urandom_range(0, 5) == 0);
        end

        @(negedge clk);
        blk = 1'b0;
        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
